// File: rtl/pre_encaps_seq.sv
// Purpose : sequences the three Keccak calls of ML-KEM pre-encapsulation (H(m), H(ek), G(m||H(ek))).
// Latency : valid 3 edges after an accepted start with zero-wait ack (2 with msg_bypass); +1 per ack wait cycle.
// Backpr. : hash requests hold their operands until hash_ack; results stay in DONE until out_ready.
// Ports   : start/k_sel/msg_bypass/encryption_key/rand_in in; busy/err status out;
//           hash_req/sel/len/in -> Keccak, hash_ack/hash_dout <- Keccak; msg/coin/pre_k/valid results,
//           out_ready from the consumer. rst is asynchronous, active low.
module pre_encaps_seq #(
   parameter int KYBER_N       = 256,
   parameter int KYBER_R_WIDTH = 12,
   parameter int K_MAX         = 4
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              start,
   input  logic [2:0]                                        k_sel,
   input  logic                                              msg_bypass,
   input  logic [KYBER_N+K_MAX*KYBER_R_WIDTH*KYBER_N-1:0]    encryption_key,
   input  logic [KYBER_N-1:0]                                rand_in,
   output logic                                              busy,
   output logic                                              err,
   output logic                                              hash_req,
   output logic [1:0]                                        hash_sel,
   output logic [15:0]                                       hash_len,
   output logic [KYBER_N+K_MAX*KYBER_R_WIDTH*KYBER_N-1:0]    hash_in,
   input  logic                                              hash_ack,
   input  logic [2*KYBER_N-1:0]                              hash_dout,
   output logic [KYBER_N-1:0]                                msg,
   output logic [KYBER_N-1:0]                                coin,
   output logic [KYBER_N-1:0]                                pre_k,
   output logic                                              valid,
   input  logic                                              out_ready
);
   localparam int EK_W = KYBER_N + K_MAX * KYBER_R_WIDTH * KYBER_N;

   typedef enum logic [2:0] {IDLE, H_MSG, H_EK, G, DONE} state_t;

   state_t               state, state_nxt;
   logic [2:0]           k_q, k_nxt;
   logic [EK_W-1:0]      key_q, key_nxt;
   logic [KYBER_N-1:0]   msg_nxt, coin_nxt, pre_k_nxt;
   logic                 err_nxt;
   logic [1:0]           sel_nxt;
   logic [15:0]          len_nxt;
   logic [EK_W-1:0]      in_nxt;
   logic                 k_legal;

   // Encoded key length in bytes: k polynomials of 12-bit coefficients plus the 32-byte rho seed.
   function automatic logic [15:0] ek_bytes(input logic [2:0] k);
      return 16'((KYBER_R_WIDTH * KYBER_N / 8) * int'(k) + KYBER_N / 8);
   endfunction

   // Keeps only the significant key bits; a shift of the full width yields an all-ones mask.
   function automatic logic [EK_W-1:0] ek_mask(input logic [2:0] k);
      logic [EK_W-1:0] ones;
      ones = '1;
      return ~(ones << (32'(ek_bytes(k)) * 8));
   endfunction

   assign k_legal = ((k_sel == 3'd2) || (k_sel == 3'd3) || (k_sel == 3'd4)) && (int'(k_sel) <= K_MAX);

   // The key is stored already masked, so the H(ek) operand is just key_q.
   // The G operand register carries H(ek) in its upper half, so no separate hash_ek flop is needed.
   always_comb begin
      state_nxt = state;
      k_nxt     = k_q;
      key_nxt   = key_q;
      msg_nxt   = msg;
      coin_nxt  = coin;
      pre_k_nxt = pre_k;
      err_nxt   = 1'b0;
      sel_nxt   = hash_sel;
      len_nxt   = hash_len;
      in_nxt    = hash_in;
      case (state)
         IDLE: begin
            if (start) begin
               if (k_legal) begin
                  k_nxt   = k_sel;
                  key_nxt = encryption_key & ek_mask(k_sel);
                  if (msg_bypass) begin
                     msg_nxt   = rand_in;
                     state_nxt = H_EK;
                     sel_nxt   = 2'd1;
                     len_nxt   = ek_bytes(k_sel);
                     in_nxt    = encryption_key & ek_mask(k_sel);
                  end else begin
                     state_nxt = H_MSG;
                     sel_nxt   = 2'd0;
                     len_nxt   = 16'(KYBER_N / 8);
                     in_nxt    = {{(EK_W-KYBER_N){1'b0}}, rand_in};
                  end
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         H_MSG: begin
            if (hash_ack) begin
               msg_nxt   = hash_dout[KYBER_N-1:0];
               state_nxt = H_EK;
               sel_nxt   = 2'd1;
               len_nxt   = ek_bytes(k_q);
               in_nxt    = key_q;
            end
         end
         H_EK: begin
            if (hash_ack) begin
               state_nxt = G;
               sel_nxt   = 2'd2;
               len_nxt   = 16'(2 * KYBER_N / 8);
               in_nxt    = {{(EK_W-2*KYBER_N){1'b0}}, hash_dout[KYBER_N-1:0], msg};
            end
         end
         G: begin
            if (hash_ack) begin
               pre_k_nxt = hash_dout[KYBER_N-1:0];
               coin_nxt  = hash_dout[2*KYBER_N-1:KYBER_N];
               state_nxt = DONE;
               sel_nxt   = 2'd0;
               len_nxt   = 16'd0;
               in_nxt    = '0;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         k_q      <= '0;
         key_q    <= '0;
         msg      <= '0;
         coin     <= '0;
         pre_k    <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         hash_req <= 1'b0;
         hash_sel <= '0;
         hash_len <= '0;
         hash_in  <= '0;
      end else begin
         state    <= state_nxt;
         k_q      <= k_nxt;
         key_q    <= key_nxt;
         msg      <= msg_nxt;
         coin     <= coin_nxt;
         pre_k    <= pre_k_nxt;
         err      <= err_nxt;
         busy     <= (state_nxt != IDLE);
         valid    <= (state_nxt == DONE);
         hash_req <= (state_nxt == H_MSG) || (state_nxt == H_EK) || (state_nxt == G);
         hash_sel <= sel_nxt;
         hash_len <= len_nxt;
         hash_in  <= in_nxt;
      end
   end

endmodule

// File: tb/tb_pre_encaps_seq.sv
// Bench for pre_encaps_seq: a stand-in Keccak responder answers requests after a programmable wait,
// a reference model derives every expected operand and result, and one negedge process compares them.
module tb_pre_encaps_seq;
   localparam int N    = 256;
   localparam int RW   = 12;
   localparam int KM   = 4;
   localparam int EK_W = N + KM * RW * N;

   typedef struct {
      logic [1:0]      sel;
      logic [15:0]     len;
      logic [EK_W-1:0] din;
   } req_t;

   logic            clk = 1'b0, rst = 1'b0, start = 1'b0, msg_bypass = 1'b0;
   logic            hash_ack = 1'b0, out_ready = 1'b0;
   logic [2:0]      k_sel = 3'd0;
   logic [EK_W-1:0] encryption_key = '0;
   logic [N-1:0]    rand_in = '0;
   logic [2*N-1:0]  hash_dout = '0;
   logic            busy, err, hash_req, valid;
   logic [1:0]      hash_sel;
   logic [15:0]     hash_len;
   logic [EK_W-1:0] hash_in;
   logic [N-1:0]    msg, coin, pre_k;

   int n_vec = 0, n_err = 0;
   int ack_delay = 0, waits = 0;
   bit ack_real = 0, stray = 0;
   logic [15:0] cur_len;
   req_t exp_q[$];
   int   len_log[$];
   logic [N-1:0] exp_msg = '0, exp_coin = '0, exp_prek = '0;

   pre_encaps_seq dut (
      .clk(clk), .rst(rst), .start(start), .k_sel(k_sel), .msg_bypass(msg_bypass),
      .encryption_key(encryption_key), .rand_in(rand_in), .busy(busy), .err(err),
      .hash_req(hash_req), .hash_sel(hash_sel), .hash_len(hash_len), .hash_in(hash_in),
      .hash_ack(hash_ack), .hash_dout(hash_dout), .msg(msg), .coin(coin), .pre_k(pre_k),
      .valid(valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [EK_W-1:0] act, input logic [EK_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         for (int i = 0; i < EK_W / 64; i++)
            if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
               $display("FAIL %s: word %0d got %0h expected %0h", name, i, act[i*64 +: 64], exp[i*64 +: 64]);
               break;
            end
      end
   endtask

   // Stand-in digest: any deterministic mixing of (sel, len, operand) exposes wrong operands downstream.
   function automatic logic [511:0] stub(input logic [1:0] sel, input logic [15:0] len, input logic [EK_W-1:0] din);
      logic [63:0]  acc;
      logic [511:0] r;
      acc = {46'd0, sel, len} ^ 64'hA5A5_5A5A_0F0F_F0F0;
      for (int i = 0; i < EK_W / 64; i++)
         acc = (acc ^ din[i*64 +: 64]) * 64'h9E37_79B9_7F4A_7C15 + 64'(i);
      for (int j = 0; j < 8; j++) begin
         acc = acc * 64'hBF58_476D_1CE4_E5B9 + 64'(j + 1);
         r[j*64 +: 64] = acc ^ (acc >> 29);
      end
      return r;
   endfunction

   function automatic logic [EK_W-1:0] rnd_key();
      logic [EK_W-1:0] k;
      for (int i = 0; i < EK_W / 32; i++) k[i*32 +: 32] = $urandom;
      return k;
   endfunction

   // Reference model: the request sequence and results a pre-encapsulation must produce.
   task automatic build_exp(input int k, input bit byp, input logic [N-1:0] rnd, input logic [EK_W-1:0] key);
      req_t r;
      logic [EK_W-1:0] mk;
      logic [511:0] d;
      logic [N-1:0] m, ek;
      int lb;
      exp_q.delete();
      case (k)
         2: lb = 800;
         3: lb = 1184;
         default: lb = 1568;
      endcase
      for (int i = 0; i < EK_W; i++) mk[i] = (i < lb * 8) ? key[i] : 1'b0;
      if (byp) m = rnd;
      else begin
         r.sel = 2'd0; r.len = 16'd32; r.din = EK_W'(rnd);
         exp_q.push_back(r);
         d = stub(r.sel, r.len, r.din);
         m = d[N-1:0];
      end
      r.sel = 2'd1; r.len = 16'(lb); r.din = mk;
      exp_q.push_back(r);
      d = stub(r.sel, r.len, r.din);
      ek = d[N-1:0];
      r.sel = 2'd2; r.len = 16'd64; r.din = EK_W'({ek, m});
      exp_q.push_back(r);
      d = stub(r.sel, r.len, r.din);
      exp_msg = m; exp_prek = d[N-1:0]; exp_coin = d[2*N-1:N];
   endtask

   // Keccak responder plus the single per-cycle comparator.
   always @(negedge clk) begin
      if (hash_ack) begin
         hash_ack = 1'b0;
         if (ack_real) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            len_log.push_back(int'(cur_len));
         end
         ack_real = 0;
         waits = 0;
      end
      if (hash_req) begin
         if (exp_q.size() == 0) check("unexpected_req", 512'(hash_req), 512'(0));
         else begin
            check("hash_sel", 512'(hash_sel), 512'(exp_q[0].sel));
            check("hash_len", 512'(hash_len), 512'(exp_q[0].len));
            check_wide("hash_in", hash_in, exp_q[0].din);
            if (waits >= ack_delay) begin
               hash_ack = 1'b1; ack_real = 1;
               hash_dout = stub(hash_sel, hash_len, hash_in);
               cur_len = hash_len;
            end else waits++;
         end
      end else if (!hash_ack) waits = 0;
      if (stray) begin
         hash_ack = 1'b1; ack_real = 0; stray = 0;
         hash_dout = {16{$urandom}};
      end
      if (valid) begin
         check("msg", 512'(msg), 512'(exp_msg));
         check("coin", 512'(coin), 512'(exp_coin));
         check("pre_k", 512'(pre_k), 512'(exp_prek));
      end
   end

   task automatic run_op(input int k, input bit byp, input logic [N-1:0] rnd, input logic [EK_W-1:0] key,
                         input int delay, input int exp_lat, input int hold);
      int cyc;
      build_exp(k, byp, rnd, key);
      len_log.delete();
      ack_delay = delay;
      @(negedge clk);
      start = 1'b1; k_sel = 3'(k); msg_bypass = byp; rand_in = rnd; encryption_key = key;
      @(posedge clk); #1;
      start = 1'b0; rand_in = ~rnd; encryption_key = ~key; msg_bypass = !byp;
      check("busy_after_start", 512'(busy), 512'(1));
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (!valid && cyc < 200);
      check("latency", 512'(cyc), 512'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); start = 1'b1; k_sel = 3'd2; rand_in = N'($urandom);
         @(posedge clk); #1; start = 1'b0;
         check("hold_valid", 512'(valid), 512'(1));
         check("hold_err", 512'(err), 512'(0));
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check("valid_drop", 512'(valid), 512'(0));
      check("busy_drop", 512'(busy), 512'(0));
      check("msg_retained", 512'(msg), 512'(exp_msg));
      check("pre_k_retained", 512'(pre_k), 512'(exp_prek));
      check("requests_left", 512'(exp_q.size()), 512'(0));
   endtask

   initial begin
      logic [N-1:0] seed;
      int bad_k[2];
      bad_k = '{5, 0};
      #1;
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_valid", 512'(valid), 512'(0));
      check("rst_req", 512'(hash_req), 512'(0));
      check("rst_msg", 512'(msg), 512'(0));
      check("rst_len", 512'(hash_len), 512'(0));
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      // Scenario 1: k=3, zero-wait ack.
      seed = 256'h7c9935a0b07694aa0c6d10e4db6b1add2fd81a25ccb148032dcd739936737f2d;
      run_op(3, 0, seed, rnd_key(), 0, 3, 0);
      check("s1_nlens", 512'(len_log.size()), 512'(3));
      check("s1_len0", 512'(len_log[0]), 512'(32));
      check("s1_len1", 512'(len_log[1]), 512'(1184));
      check("s1_len2", 512'(len_log[2]), 512'(64));

      // Scenario 2: k=2, bypass, 5 wait cycles per request.
      run_op(2, 1, seed, rnd_key(), 5, 12, 0);
      check("s2_msg_is_seed", 512'(msg), 512'(seed));
      check("s2_nlens", 512'(len_log.size()), 512'(2));
      check("s2_len0", 512'(len_log[0]), 512'(800));
      check("s2_len1", 512'(len_log[1]), 512'(64));

      // Scenario 3: illegal ranks rejected, then k=4.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); start = 1'b1; k_sel = 3'(bad_k[i]);
         @(posedge clk); #1; start = 1'b0;
         check("err_pulse", 512'(err), 512'(1));
         check("err_busy", 512'(busy), 512'(0));
         check("err_req", 512'(hash_req), 512'(0));
         @(posedge clk); #1;
         check("err_clear", 512'(err), 512'(0));
      end
      run_op(4, 0, N'({8{$urandom}}), rnd_key(), 1, 6, 0);
      check("s3_len1", 512'(len_log[1]), 512'(1568));

      // Scenario 4: consumer stalls 10 cycles in DONE while start pulses.
      run_op(3, 1, N'({8{$urandom}}), rnd_key(), 0, 2, 10);

      // Scenario 5: reset in the middle of an H(ek) wait, stray ack afterwards.
      build_exp(4, 0, seed, rnd_key());
      ack_delay = 0;
      @(negedge clk); start = 1'b1; k_sel = 3'd4; msg_bypass = 1'b0; rand_in = seed;
      encryption_key = rnd_key();
      build_exp(4, 0, seed, encryption_key);
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; ack_delay = 1000;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("abort_req", 512'(hash_req), 512'(0));
      check("abort_busy", 512'(busy), 512'(0));
      check("abort_len", 512'(hash_len), 512'(0));
      check("abort_msg", 512'(msg), 512'(0));
      check("abort_coin", 512'(coin), 512'(0));
      check_wide("abort_in", hash_in, '0);
      exp_q.delete();
      @(posedge clk); #3 rst = 1'b1; stray = 1;
      run_op(2, 0, N'({8{$urandom}}), rnd_key(), 2, 9, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
